// File: rtl/pc_fetch_sequencer.sv
// ============================================================================
// PcFetchSequencer (module pc_fetch_sequencer)
// ----------------------------------------------------------------------------
// Fetch-side controller for the PC datapath. Owns the fetch PC and walks
// instruction memory through a req/ack handshake. It applies redirects (taken
// branch, jump, jump-register) and halt/resume. It also throws away responses
// that a redirect has made stale.
//
// Optional feature (compile-time macro):
//   FETCH_TIMEOUT_EN - when defined, a FETCH that waits MAX_WAIT cycles without
//                      an ack moves to a sticky FAULT state. Only reset leaves
//                      that state. When undefined, there is no wait counter, no
//                      FAULT state, and fault is tied low.
//
// Parameters:
//   ADDR_W    fetch address width, word addressed (+1 per instruction)
//   RESET_PC  fetch PC loaded on reset
//   MAX_WAIT  ack timeout in cycles (only meaningful with FETCH_TIMEOUT_EN)
//
// Ports:
//   clock        in   rising-edge clock
//   reset        in   asynchronous, active-high reset
//   halt         in   level: stop after the current fetch completes
//   resume       in   pulse: leave HALT while halt is low
//   branch/zero  in   branch taken when both are high
//   jmp, jr      in   unconditional redirects
//   target       in   redirect target, selected upstream
//   imem_req     out  fetch request
//   imem_addr    out  fetch address, stable while a request waits for ack
//   imem_ack     in   read data valid this cycle
//   imem_rdata   in   instruction word
//   instr        out  delivered instruction
//   instr_valid  out  one-cycle strobe per delivered instruction
//   pc           out  address of the delivered instruction
//   halted       out  high in HALT (and FAULT)
//   fault        out  fetch timeout indication
// ============================================================================
module pc_fetch_sequencer #(
   parameter int                 ADDR_W   = 32,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0,
   parameter int                 MAX_WAIT = 15
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              halt,
   input  logic              resume,
   input  logic              branch,
   input  logic              zero,
   input  logic              jmp,
   input  logic              jr,
   input  logic [ADDR_W-1:0] target,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [31:0]       imem_rdata,
   output logic [31:0]       instr,
   output logic              instr_valid,
   output logic [ADDR_W-1:0] pc,
   output logic              halted,
   output logic              fault
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_HALT  = 2'd2;
`ifdef FETCH_TIMEOUT_EN
   localparam logic [1:0] S_FAULT = 2'd3;
   localparam int         WAIT_W  = $clog2(MAX_WAIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
`endif

   logic [1:0]        state_q,     state_d;
   logic [ADDR_W-1:0] fetchPc_q,   fetchPc_d;
   logic              pend_q,      pend_d;
   logic [ADDR_W-1:0] pendTgt_q,   pendTgt_d;
   logic              imemReq_q;
   logic [ADDR_W-1:0] imemAddr_q;
   logic [31:0]       instr_q;
   logic              instrValid_q;
   logic [ADDR_W-1:0] pc_q;
   logic              deliver;
   logic              take;

   assign take = (branch & zero) | jmp | jr;

`ifdef FETCH_TIMEOUT_EN
   logic [WAIT_W-1:0] waitCnt_q, waitCnt_d;
`endif

   // Next-state logic. A response is delivered only when it was not made
   // stale by a redirect. A redirect that lands in the same cycle as an ack
   // uses the live target. Otherwise, an earlier redirect recorded in
   // pend/pendTgt supplies the new fetch PC. On an ack, the redirect decides
   // fetch_pc and halt decides whether the next request is issued. So a
   // redirect coinciding with halt is remembered, and fetching resumes there.
   always_comb begin
      state_d   = state_q;
      fetchPc_d = fetchPc_q;
      pend_d    = pend_q;
      pendTgt_d = pendTgt_q;
      deliver   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (take) fetchPc_d = target;
            state_d = halt ? S_HALT : S_FETCH;
         end
         S_FETCH: begin
            if (imem_ack) begin
               if (take) begin
                  fetchPc_d = target;
               end else if (pend_q) begin
                  fetchPc_d = pendTgt_q;
               end else begin
                  deliver   = 1'b1;
                  fetchPc_d = fetchPc_q + 1'b1;
               end
               pend_d  = 1'b0;
               state_d = halt ? S_HALT : S_FETCH;
            end else if (take) begin
               pend_d    = 1'b1;
               pendTgt_d = target;
            end
         end
         S_HALT: begin
            if (take) fetchPc_d = target;
            if (resume && !halt) state_d = S_FETCH;
         end
         default: begin
            state_d = state_q;
         end
      endcase
`ifdef FETCH_TIMEOUT_EN
      // The timeout outranks any redirect. It only fires on a cycle without
      // an ack, so fetch_pc is already unchanged.
      if (state_q == S_FETCH && !imem_ack && waitCnt_q == WAIT_LAST) begin
         state_d = S_FAULT;
      end
`endif
   end

`ifdef FETCH_TIMEOUT_EN
   // Wait counter: counts FETCH cycles without an ack. It is cleared by an ack
   // or by leaving FETCH, and it is frozen in FAULT.
   always_comb begin
      waitCnt_d = '0;
      if (state_q == S_FETCH && !imem_ack) waitCnt_d = waitCnt_q + 1'b1;
      else if (state_q == S_FAULT)         waitCnt_d = waitCnt_q;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) waitCnt_q <= '0;
      else       waitCnt_q <= waitCnt_d;
   end
`endif

   // State and output registers. The request and its address are registered
   // from the next state, so a new request appears the cycle after an ack.
   // The address only changes when a request is issued, so it holds in HALT.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         fetchPc_q    <= RESET_PC;
         pend_q       <= 1'b0;
         pendTgt_q    <= '0;
         imemReq_q    <= 1'b0;
         imemAddr_q   <= RESET_PC;
         instr_q      <= '0;
         instrValid_q <= 1'b0;
         pc_q         <= RESET_PC;
      end else begin
         state_q      <= state_d;
         fetchPc_q    <= fetchPc_d;
         pend_q       <= pend_d;
         pendTgt_q    <= pendTgt_d;
         imemReq_q    <= (state_d == S_FETCH);
         if (state_d == S_FETCH) imemAddr_q <= fetchPc_d;
         instrValid_q <= deliver;
         if (deliver) begin
            instr_q <= imem_rdata;
            pc_q    <= fetchPc_q;
         end
      end
   end

   assign imem_req    = imemReq_q;
   assign imem_addr   = imemAddr_q;
   assign instr       = instr_q;
   assign instr_valid = instrValid_q;
   assign pc          = pc_q;

`ifdef FETCH_TIMEOUT_EN
   assign halted = (state_q == S_HALT) || (state_q == S_FAULT);
   assign fault  = (state_q == S_FAULT);
`else
   assign halted = (state_q == S_HALT);
   assign fault  = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// ============================================================================
// Directed testbench for pc_fetch_sequencer. Inputs are driven 1 time unit
// after each rising edge. Outputs are sampled at the same point, so every
// check sees the register state produced by the previous edge.
// ============================================================================
module tb_pc_fetch_sequencer;

   localparam int AW = 32;

   logic          clock = 1'b0;
   logic          reset;
   logic          halt, resume, branch, zero, jmp, jr;
   logic [AW-1:0] target;
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic          imem_ack;
   logic [31:0]   imem_rdata;
   logic [31:0]   instr;
   logic          instr_valid;
   logic [AW-1:0] pc;
   logic          halted;
   logic          fault;

   int testsRun    = 0;
   int testsFailed = 0;

   pc_fetch_sequencer #(.ADDR_W(AW), .RESET_PC('0), .MAX_WAIT(15)) dut (
      .clock(clock), .reset(reset), .halt(halt), .resume(resume),
      .branch(branch), .zero(zero), .jmp(jmp), .jr(jr), .target(target),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
      .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
      .pc(pc), .halted(halted), .fault(fault)
   );

   // Free-running clock, 10 time-unit period.
   always #5 clock = ~clock;

   // Advance one clock and settle just past the edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Present an imem response for the coming edge, then advance.
   task automatic applyStimulus(input logic ack, input logic [31:0] rdata);
      imem_ack   = ack;
      imem_rdata = rdata;
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b1; halt = 0; resume = 0; branch = 0; zero = 0; jmp = 0; jr = 0;
      target = '0; imem_ack = 0; imem_rdata = '0;
      #12;
      testsRun++; if (imem_req !== 1'b0)    begin testsFailed++; $display("[TB] FAIL reset_req got %b want 0", imem_req); end
      testsRun++; if (imem_addr !== 32'h0)  begin testsFailed++; $display("[TB] FAIL reset_addr got %h want 0", imem_addr); end
      testsRun++; if (instr_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_valid got %b want 0", instr_valid); end
      testsRun++; if (instr !== 32'h0 || pc !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_instr_pc got %h/%h want 0/0", instr, pc); end
      testsRun++; if (halted !== 1'b0 || fault !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_flags got %b/%b want 0/0", halted, fault); end
      @(posedge clock); #1;
      reset = 1'b0;
   endtask

   task automatic test_sequential();
      tick();
      testsRun++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin testsFailed++; $display("[TB] FAIL seq_first_req got %b/%h want 1/0", imem_req, imem_addr); end
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 32'(i));
         testsRun++; if (instr_valid !== 1'b1 || pc !== 32'(i) || instr !== 32'(i)) begin testsFailed++; $display("[TB] FAIL seq_deliver%0d got v=%b pc=%h instr=%h want v=1 pc=%h", i, instr_valid, pc, instr, i); end
         testsRun++; if (imem_addr !== 32'(i + 1)) begin testsFailed++; $display("[TB] FAIL seq_addr%0d got %h want %h", i, imem_addr, i + 1); end
      end
      applyStimulus(1'b0, 32'h0);
      testsRun++; if (instr_valid !== 1'b0 || imem_addr !== 32'h3) begin testsFailed++; $display("[TB] FAIL seq_idle got v=%b addr=%h want v=0 addr=3", instr_valid, imem_addr); end
   endtask

   task automatic test_delayed_ack();
      applyStimulus(1'b1, 32'h3);
      applyStimulus(1'b1, 32'h4);
      testsRun++; if (imem_addr !== 32'h5 || pc !== 32'h4) begin testsFailed++; $display("[TB] FAIL dly_setup got addr=%h pc=%h want 5/4", imem_addr, pc); end
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 32'h0);
         testsRun++; if (imem_addr !== 32'h5 || imem_req !== 1'b1 || instr_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL dly_hold%0d got addr=%h req=%b v=%b want 5/1/0", i, imem_addr, imem_req, instr_valid); end
      end
      applyStimulus(1'b1, 32'h5);
      testsRun++; if (instr_valid !== 1'b1 || pc !== 32'h5 || instr !== 32'h5 || imem_addr !== 32'h6) begin testsFailed++; $display("[TB] FAIL dly_ack got v=%b pc=%h instr=%h addr=%h want 1/5/5/6", instr_valid, pc, instr, imem_addr); end
      applyStimulus(1'b0, 32'h0);
      testsRun++; if (instr_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL dly_single_strobe got %b want 0", instr_valid); end
   endtask

   task automatic test_jump_pending();
      jmp = 1'b1; target = 32'h40;
      applyStimulus(1'b0, 32'h0);
      jmp = 1'b0; target = 32'h0;
      testsRun++; if (imem_addr !== 32'h6 || instr_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL jmp_hold got addr=%h v=%b want 6/0", imem_addr, instr_valid); end
      applyStimulus(1'b0, 32'h0);
      applyStimulus(1'b1, 32'hDEAD);
      testsRun++; if (instr_valid !== 1'b0 || pc !== 32'h5) begin testsFailed++; $display("[TB] FAIL jmp_drop got v=%b pc=%h want 0/5", instr_valid, pc); end
      testsRun++; if (imem_addr !== 32'h40) begin testsFailed++; $display("[TB] FAIL jmp_target got %h want 40", imem_addr); end
      applyStimulus(1'b0, 32'h0);
      testsRun++; if (instr_valid !== 1'b0 || imem_addr !== 32'h40) begin testsFailed++; $display("[TB] FAIL jmp_after got v=%b addr=%h want 0/40", instr_valid, imem_addr); end
   endtask

   task automatic test_branch();
      branch = 1'b1; zero = 1'b0; target = 32'h99;
      applyStimulus(1'b1, 32'h40);
      testsRun++; if (instr_valid !== 1'b1 || pc !== 32'h40 || imem_addr !== 32'h41) begin testsFailed++; $display("[TB] FAIL br_not_taken got v=%b pc=%h addr=%h want 1/40/41", instr_valid, pc, imem_addr); end
      zero = 1'b1; target = 32'h10;
      applyStimulus(1'b1, 32'h41);
      branch = 1'b0; zero = 1'b0; target = 32'h0;
      testsRun++; if (instr_valid !== 1'b0 || pc !== 32'h40 || imem_addr !== 32'h10) begin testsFailed++; $display("[TB] FAIL br_taken got v=%b pc=%h addr=%h want 0/40/10", instr_valid, pc, imem_addr); end
      applyStimulus(1'b0, 32'h0);
      testsRun++; if (instr_valid !== 1'b0 || imem_addr !== 32'h10) begin testsFailed++; $display("[TB] FAIL br_after got v=%b addr=%h want 0/10", instr_valid, imem_addr); end
   endtask

   task automatic test_halt();
      jmp = 1'b1; target = 32'h7;
      applyStimulus(1'b1, 32'h10);
      jmp = 1'b0; target = 32'h0;
      testsRun++; if (imem_addr !== 32'h7 || instr_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL halt_setup got addr=%h v=%b want 7/0", imem_addr, instr_valid); end
      halt = 1'b1;
      applyStimulus(1'b1, 32'h7);
      testsRun++; if (instr_valid !== 1'b1 || pc !== 32'h7 || instr !== 32'h7) begin testsFailed++; $display("[TB] FAIL halt_deliver got v=%b pc=%h instr=%h want 1/7/7", instr_valid, pc, instr); end
      testsRun++; if (imem_req !== 1'b0 || halted !== 1'b1) begin testsFailed++; $display("[TB] FAIL halt_enter got req=%b halted=%b want 0/1", imem_req, halted); end
      applyStimulus(1'b0, 32'h0);
      testsRun++; if (instr_valid !== 1'b0 || halted !== 1'b1 || pc !== 32'h7) begin testsFailed++; $display("[TB] FAIL halt_stay got v=%b halted=%b pc=%h want 0/1/7", instr_valid, halted, pc); end
      resume = 1'b1;
      applyStimulus(1'b0, 32'h0);
      resume = 1'b0;
      testsRun++; if (halted !== 1'b1 || imem_req !== 1'b0) begin testsFailed++; $display("[TB] FAIL halt_resume_ignored got halted=%b req=%b want 1/0", halted, imem_req); end
      halt = 1'b0;
      applyStimulus(1'b0, 32'h0);
      testsRun++; if (halted !== 1'b1) begin testsFailed++; $display("[TB] FAIL halt_no_resume got halted=%b want 1", halted); end
      resume = 1'b1;
      applyStimulus(1'b0, 32'h0);
      resume = 1'b0;
      testsRun++; if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h8) begin testsFailed++; $display("[TB] FAIL halt_resume got halted=%b req=%b addr=%h want 0/1/8", halted, imem_req, imem_addr); end
   endtask

   task automatic test_wrap();
      jmp = 1'b1; target = 32'hFFFF_FFFF;
      applyStimulus(1'b1, 32'h8);
      jmp = 1'b0; target = 32'h0;
      testsRun++; if (imem_addr !== 32'hFFFF_FFFF) begin testsFailed++; $display("[TB] FAIL wrap_setup got %h want ffffffff", imem_addr); end
      applyStimulus(1'b1, 32'h1234);
      testsRun++; if (instr_valid !== 1'b1 || pc !== 32'hFFFF_FFFF || instr !== 32'h1234) begin testsFailed++; $display("[TB] FAIL wrap_deliver got v=%b pc=%h instr=%h want 1/ffffffff/1234", instr_valid, pc, instr); end
      testsRun++; if (imem_addr !== 32'h0) begin testsFailed++; $display("[TB] FAIL wrap_addr got %h want 0", imem_addr); end
   endtask

   task automatic test_latest_wins();
      jmp = 1'b1; target = 32'h100;
      applyStimulus(1'b0, 32'h0);
      jmp = 1'b0; jr = 1'b1; target = 32'h200;
      applyStimulus(1'b0, 32'h0);
      jr = 1'b0; target = 32'h0;
      testsRun++; if (imem_addr !== 32'h0) begin testsFailed++; $display("[TB] FAIL latest_hold got %h want 0", imem_addr); end
      applyStimulus(1'b1, 32'h0);
      testsRun++; if (instr_valid !== 1'b0 || imem_addr !== 32'h200) begin testsFailed++; $display("[TB] FAIL latest_target got v=%b addr=%h want 0/200", instr_valid, imem_addr); end
   endtask

   task automatic test_reset_abort();
      imem_ack = 1'b1; imem_rdata = 32'hBAD;
      #3 reset = 1'b1;
      #1;
      testsRun++; if (imem_req !== 1'b0 || imem_addr !== 32'h0 || pc !== 32'h0) begin testsFailed++; $display("[TB] FAIL abort_reset got req=%b addr=%h pc=%h want 0/0/0", imem_req, imem_addr, pc); end
      @(posedge clock); #1;
      reset = 1'b0;
      tick();
      testsRun++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL abort_late_ack got req=%b addr=%h v=%b want 1/0/0", imem_req, imem_addr, instr_valid); end
      applyStimulus(1'b1, 32'hA0);
      testsRun++; if (instr_valid !== 1'b1 || pc !== 32'h0 || instr !== 32'hA0) begin testsFailed++; $display("[TB] FAIL abort_refetch got v=%b pc=%h instr=%h want 1/0/a0", instr_valid, pc, instr); end
   endtask

`ifdef FETCH_TIMEOUT_EN
   task automatic test_timeout();
      int n;
      n = 0;
      while (fault !== 1'b1 && n < 40) begin
         applyStimulus(1'b0, 32'h0);
         n++;
      end
      testsRun++; if (n != 15) begin testsFailed++; $display("[TB] FAIL timeout_cycles got %0d want 15", n); end
      testsRun++; if (fault !== 1'b1 || halted !== 1'b1 || imem_req !== 1'b0) begin testsFailed++; $display("[TB] FAIL timeout_flags got f=%b h=%b req=%b want 1/1/0", fault, halted, imem_req); end
      reset = 1'b1;
      #1;
      testsRun++; if (fault !== 1'b0 || halted !== 1'b0) begin testsFailed++; $display("[TB] FAIL timeout_clear got f=%b h=%b want 0/0", fault, halted); end
      @(posedge clock); #1;
      reset = 1'b0;
   endtask
`else
   task automatic test_no_timeout();
      for (int i = 0; i < 20; i++) applyStimulus(1'b0, 32'h0);
      testsRun++; if (fault !== 1'b0 || halted !== 1'b0 || imem_req !== 1'b1) begin testsFailed++; $display("[TB] FAIL no_timeout got f=%b h=%b req=%b want 0/0/1", fault, halted, imem_req); end
   endtask
`endif

   // Scenario sequence; each task leaves the DUT in the state the next expects.
   initial begin
      test_reset();
      test_sequential();
      test_delayed_ack();
      test_jump_pending();
      test_branch();
      test_halt();
      test_wrap();
      test_latest_wins();
      test_reset_abort();
`ifdef FETCH_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
